// File: rtl/debounce_filter.sv
// ----------------------------------------------------------------------------
// debounce_filter
//
// Synchronizes a raw, possibly bouncing input level and only passes a level
// change to dout after it has been seen on DEBOUNCE_CYCLES consecutive
// synchronized samples. Shorter pulses are rejected.
//
// Parameters:
//   SYNC_STAGES     - synchronizer flops on din (>= 2)
//   DEBOUNCE_CYCLES - consecutive stable samples required to accept a change (>= 1)
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous, active-high reset
//   din      in   raw level, asynchronous to clk
//   dout     out  debounced, registered level
//   settling out  high while a candidate level change is being qualified
// ----------------------------------------------------------------------------
module debounce_filter #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic settling
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StStableLo,
      StWaitHi,
      StStableHi,
      StWaitLo
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic                   dout_q, settling_q;

   // Synchronizer chain; only the last stage is used downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StStableLo: begin
            cnt_d = '0;
            if (s) begin
               // A single required sample qualifies on the very first edge.
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = StStableHi;
               end else begin
                  state_d = StWaitHi;
                  cnt_d   = CntW'(1);
               end
            end
         end
         StWaitHi: begin
            if (!s) begin
               state_d = StStableLo;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StStableHi;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StStableHi: begin
            cnt_d = '0;
            if (!s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = StStableLo;
               end else begin
                  state_d = StWaitLo;
                  cnt_d   = CntW'(1);
               end
            end
         end
         StWaitLo: begin
            if (s) begin
               state_d = StStableHi;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               state_d = StStableLo;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = StStableLo;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with it in flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StStableLo;
         cnt_q      <= '0;
         dout_q     <= 1'b0;
         settling_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dout_q     <= (state_d == StStableHi) || (state_d == StWaitLo);
         settling_q <= (state_d == StWaitHi) || (state_d == StWaitLo);
      end
   end

   assign dout     = dout_q;
   assign settling = settling_q;

endmodule

// File: tb/tb_debounce_filter.sv
// ----------------------------------------------------------------------------
// tb_debounce_filter
//
// Drives two instances (DEBOUNCE_CYCLES=4 and =1, both SYNC_STAGES=2) from the
// same din. A sliding-window reference model pushes the expected outputs of
// every edge into a queue; each scenario task pops and compares them, and also
// checks the fixed cycle timings directly.
// ----------------------------------------------------------------------------
module tb_debounce_filter;

   logic clk = 1'b0;
   logic reset;
   logic din;
   logic dout0, settling0;
   logic dout1, settling1;

   always #5 clk = ~clk;

   debounce_filter #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .din     (din),
      .dout    (dout0),
      .settling(settling0)
   );

   debounce_filter #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(1)
   ) dut1 (
      .clk     (clk),
      .reset   (reset),
      .din     (din),
      .dout    (dout1),
      .settling(settling1)
   );

   // Downstream rising-edge detector fed by dout0.
   logic det_prev, det_pulse;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         det_prev  <= 1'b0;
         det_pulse <= 1'b0;
      end else begin
         det_prev  <= dout0;
         det_pulse <= dout0 & ~det_prev;
      end
   end

   int errors = 0;
   int checks = 0;

   // Scoreboard entries: {dout0, settling0, dout1, settling1}.
   logic [3:0] sb[$];

   // Reference model: dout flips once the last depth samples of s all
   // differ from it; settling is high while the latest sample disagrees.
   logic [1:0] m_sync;
   logic [3:0] m_hist[2];
   int         m_depth[2] = '{4, 1};
   logic       m_dout[2];
   logic       m_set[2];

   task automatic model_reset();
      m_sync = '0;
      for (int i = 0; i < 2; i++) begin
         m_hist[i] = '0;
         m_dout[i] = 1'b0;
         m_set[i]  = 1'b0;
      end
      sb.delete();
   endtask

   // Drive din for one edge, advance the model, push the expectation, and
   // return 1 time unit after the edge.
   task automatic drive(input logic d);
      logic s_old;
      logic all;
      din = d;
      @(posedge clk);
      s_old  = m_sync[1];
      m_sync = {m_sync[0], d};
      for (int i = 0; i < 2; i++) begin
         m_hist[i] = {m_hist[i][2:0], s_old};
         all = 1'b1;
         for (int k = 0; k < m_depth[i]; k++) begin
            if (m_hist[i][k] == m_dout[i]) all = 1'b0;
         end
         if (all) m_dout[i] = ~m_dout[i];
         m_set[i] = (s_old != m_dout[i]);
      end
      sb.push_back({m_dout[0], m_set[0], m_dout[1], m_set[1]});
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] exp;
      reset = 1'b1;
      din   = 1'b0;
      #1;
      checks++;
      if ({dout0, settling0, dout1, settling1} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_async: got %b want 0000", {dout0, settling0, dout1, settling1});
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1'b0);
         exp = sb.pop_front();
         checks++;
         if ({dout0, settling0, dout1, settling1} !== exp || dout0 !== 1'b0 ||
             settling0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_low[%0d]: got %b want %b", i,
                     {dout0, settling0, dout1, settling1}, exp);
         end
      end
   endtask

   task automatic test_press();
      logic [3:0] exp;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1);
         exp = sb.pop_front();
         checks++;
         if ({dout0, settling0, dout1, settling1} !== exp) begin
            errors++;
            $display("FAIL press[%0d]: got %b want %b", i, {dout0, settling0, dout1, settling1}, exp);
         end
         checks++;
         if (dout0 !== (i >= 5) || settling0 !== (i >= 2 && i <= 4) ||
             dout1 !== (i >= 2) || settling1 !== 1'b0) begin
            errors++;
            $display("FAIL press_timing[%0d]: got %b want %b", i,
                     {dout0, settling0, dout1, settling1},
                     {1'(i >= 5), 1'(i >= 2 && i <= 4), 1'(i >= 2), 1'b0});
         end
      end
   endtask

   task automatic test_release();
      logic [3:0] exp;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0);
         exp = sb.pop_front();
         checks++;
         if ({dout0, settling0, dout1, settling1} !== exp || dout0 !== (i < 5)) begin
            errors++;
            $display("FAIL release[%0d]: got %b want %b dout0=%b", i,
                     {dout0, settling0, dout1, settling1}, exp, 1'(i < 5));
         end
      end
   endtask

   task automatic test_glitch();
      logic [3:0] exp;
      for (int i = 0; i < 11; i++) begin
         drive(i < 3);
         exp = sb.pop_front();
         checks++;
         if ({dout0, settling0, dout1, settling1} !== exp || dout0 !== 1'b0) begin
            errors++;
            $display("FAIL glitch[%0d]: got %b want %b", i, {dout0, settling0, dout1, settling1}, exp);
         end
         if (i == 2) begin
            checks++;
            if (settling0 !== 1'b1) begin
               errors++;
               $display("FAIL glitch_settling: got %b want 1", settling0);
            end
         end
      end
      checks++;
      if (settling0 !== 1'b0 || dout0 !== 1'b0) begin
         errors++;
         $display("FAIL glitch_end: got %b%b want 00", dout0, settling0);
      end
   endtask

   task automatic test_bounce();
      logic [3:0] exp;
      for (int i = 0; i < 20; i++) begin
         drive((i >= 10) ? 1'b1 : ((i % 2) == 0));
         exp = sb.pop_front();
         checks++;
         if ({dout0, settling0, dout1, settling1} !== exp || dout0 !== (i >= 15)) begin
            errors++;
            $display("FAIL bounce[%0d]: got %b want %b dout0=%b", i,
                     {dout0, settling0, dout1, settling1}, exp, 1'(i >= 15));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp;
      // Start releasing from dout=1 so the block sits in WAIT_LO with cnt=2.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0);
         exp = sb.pop_front();
         checks++;
         if ({dout0, settling0, dout1, settling1} !== exp) begin
            errors++;
            $display("FAIL mid_pre[%0d]: got %b want %b", i, {dout0, settling0, dout1, settling1}, exp);
         end
      end
      checks++;
      if (dout0 !== 1'b1 || settling0 !== 1'b1) begin
         errors++;
         $display("FAIL mid_waitlo: got %b%b want 11", dout0, settling0);
      end
      din = 1'b1;
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if ({dout0, settling0, dout1, settling1} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_async: got %b want 0000", {dout0, settling0, dout1, settling1});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1);
         exp = sb.pop_front();
         checks++;
         if ({dout0, settling0, dout1, settling1} !== exp || dout0 !== (i >= 5)) begin
            errors++;
            $display("FAIL post_reset_hi[%0d]: got %b want %b dout0=%b", i,
                     {dout0, settling0, dout1, settling1}, exp, 1'(i >= 5));
         end
      end
   endtask

   task automatic test_edge_detect();
      logic [3:0] exp;
      int pulses = 0;
      int rise   = -1;
      int pidx   = -1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0);
         exp = sb.pop_front();
         checks++;
         if ({dout0, settling0, dout1, settling1} !== exp) begin
            errors++;
            $display("FAIL det_low[%0d]: got %b want %b", i, {dout0, settling0, dout1, settling1}, exp);
         end
      end
      for (int i = 0; i < 12; i++) begin
         drive(1'b1);
         exp = sb.pop_front();
         checks++;
         if ({dout0, settling0, dout1, settling1} !== exp) begin
            errors++;
            $display("FAIL det_press[%0d]: got %b want %b", i, {dout0, settling0, dout1, settling1}, exp);
         end
         if (dout0 === 1'b1 && rise < 0) rise = i;
         if (det_pulse === 1'b1) begin
            pulses++;
            if (pidx < 0) pidx = i;
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL det_pulse_count: got %0d want 1", pulses);
      end
      checks++;
      if (rise != 5 || pidx != 6) begin
         errors++;
         $display("FAIL det_pulse_timing: got rise=%0d pulse=%0d want rise=5 pulse=6", rise, pidx);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      din   = 1'b0;
      model_reset();
      test_reset();
      test_press();
      test_release();
      test_glitch();
      test_bounce();
      test_reset_mid();
      test_edge_detect();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/debounce_filter.md
DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on din (legal range >= 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized samples needed before dout changes (legal range >= 1).
REQ-003 SHALL have port clk  input  1  sole clock; all flops rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port din  input  1  raw level from a switch or pin, asynchronous to clk, may bounce.
REQ-006 SHALL have port dout  output  1  debounced, clk-synchronous level; feeds the downstream edge detector's din.
REQ-007 SHALL have port settling  output  1  high while a candidate level change is being qualified.

Function
REQ-008 SHALL pass din through a chain of SYNC_STAGES flops; the last flop's output is "s"; no other logic reads din.
REQ-009 SHALL implement a 4-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-010 SHALL hold a counter cnt of width $clog2(DEBOUNCE_CYCLES+1) bits; it never wraps.
REQ-011 STABLE_LO: if s==1, go to WAIT_HI with cnt=1; else stay with cnt=0.
REQ-012 WAIT_HI: if s==0, go to STABLE_LO with cnt=0 (glitch rejected, dout unchanged).
REQ-013 WAIT_HI: if s==1 and cnt==DEBOUNCE_CYCLES-1, go to STABLE_HI with cnt=0; else increment cnt.
REQ-014 STABLE_HI, WAIT_LO: mirror REQ-011..013 with s inverted, returning to STABLE_LO on qualification.
REQ-015 DEBOUNCE_CYCLES==1: the change from STABLE_x to the opposite STABLE state SHALL happen in one edge; WAIT states are not entered.
REQ-016 dout SHALL be registered: 1 in STABLE_HI and WAIT_LO, 0 in STABLE_LO and WAIT_HI.
REQ-017 settling SHALL be 1 exactly in WAIT_HI and WAIT_LO.
REQ-018 Latency: a clean din change set up before edge k SHALL appear on dout after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-019 A pulse on s shorter than DEBOUNCE_CYCLES consecutive samples SHALL never change dout.
REQ-020 An s toggle back to the current dout value on the qualifying edge SHALL abort qualification; the change is not taken.
REQ-021 dout SHALL change at most once per qualification and SHALL never glitch (single flop output).
REQ-022 Successive dout transitions SHALL be separated by at least DEBOUNCE_CYCLES clk cycles.

Reset
REQ-023 Assertion of reset SHALL immediately, without a clk edge, clear all sync flops, cnt=0, state=STABLE_LO, dout=0, settling=0.
REQ-024 Reset asserted mid-qualification SHALL discard the pending change; dout stays 0 until requalified after release.
REQ-025 After reset deassertion with din held 1, dout SHALL rise at the edge given by REQ-018, counting from the first edge after release.
REQ-026 Reset deassertion SHALL be synchronized externally; the block needs no reset synchronizer.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-027 Reset with din=0, release, hold 20 cycles -> dout=0, settling=0 throughout.
REQ-028 din 0->1 set up before edge 0, held -> settling=1 after edges 2-4, dout=1 after edge 5, settling=0 after edge 5.
REQ-029 din pulses high for 3 cycles, then low -> dout stays 0, settling rises then returns to 0, state back to STABLE_LO.
REQ-030 Bounce: din toggles every cycle for 10 cycles, then holds 1 -> dout=0 during the bounce, rises 5 edges after the final toggle.
REQ-031 dout=1 with WAIT_LO and cnt=2, reset asserted between edges -> dout=0 and settling=0 immediately, before the next clk edge.
REQ-032 Drive dout into the edge detector: one clean din press -> exactly one single-cycle detector pulse, 1 cycle after dout rises.
